// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants for the RX and TX stages
package uart_pkg;
  localparam int DATA_BITS = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchroniser for an asynchronous input, resets to 1 (idle line)
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [1:0] ff;
  assign q = ff[1];
  // shift the async input through two flops to settle metastability
  always_ff @(posedge clk or posedge rst)
    if (rst) ff <= 2'b11;
    else ff <= {ff[0], d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (8E1 with even-parity check when RX_PARITY_EN is defined)
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD_RATE    = 9600,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RxD,
  output logic [DATA_BITS-1:0] RxData,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);
  localparam int CW = clog2(CLKS_PER_BIT);
  localparam int BW = clog2(DATA_BITS);
  localparam logic [CW-1:0] MID = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  state_t               state;
  logic [CW-1:0]        clk_cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 rxd_s;
  uart_sync2 u_sync (.clk(clk), .rst(reset), .d(RxD), .q(rxd_s));
  assign busy = state != IDLE;
`ifdef RX_PARITY_EN
  logic par_bit;
`else
  assign parity_err = 1'b0;
`endif
  // receive FSM: start detect, centre sampling of data/parity/stop, registered strobes
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      RxData    <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      clk_cnt <= clk_cnt + 1'b1;
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          if (!rxd_s) state <= START;
        end
        START:
          if (clk_cnt == MID) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            state   <= rxd_s ? IDLE : DATA;
          end
        DATA:
          if (clk_cnt == LAST) begin
            clk_cnt <= '0;
            shift   <= {rxd_s, shift[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
`ifdef RX_PARITY_EN
            if (bit_idx == LAST_BIT) state <= PARITY;
`else
            if (bit_idx == LAST_BIT) state <= STOP;
`endif
          end
`ifdef RX_PARITY_EN
        PARITY:
          if (clk_cnt == LAST) begin
            clk_cnt <= '0;
            par_bit <= rxd_s;
            state   <= STOP;
          end
`endif
        STOP:
          if (clk_cnt == LAST) begin
            clk_cnt <= '0;
            state   <= IDLE;
            if (!rxd_s) frame_err <= 1'b1;
`ifdef RX_PARITY_EN
            else if (^{shift, par_bit}) parity_err <= 1'b1;
`endif
            else begin
              RxData   <= shift;
              rx_valid <= 1'b1;
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx against a frame-level model
module tb_uart_rx;
  localparam int CPB = 16;
`ifdef RX_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, RxD = 1'b1;
  logic [7:0] RxData;
  logic rx_valid, frame_err, parity_err, busy;
  int n_cmp = 0, n_err = 0;
  int n_valid = 0, n_ferr = 0, n_perr = 0, n_both = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_data = 8'h00;
  int exp_ferr = 0, exp_perr = 0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .RxD(RxD), .RxData(RxData),
    .rx_valid(rx_valid), .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // strobe monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid++;
      got_q.push_back(RxData);
    end
    if (frame_err) n_ferr++;
    if (parity_err) n_perr++;
    if (rx_valid && frame_err) n_both++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic bit_out(input logic b);
    RxD = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    RxD = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  // drive one frame and record what a correct receiver must report for it
  task automatic send(input logic [7:0] d, input logic stop, input logic par_ok);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
    if (HAS_PAR) bit_out(^d ^ ~par_ok);
    bit_out(stop);
    RxD = 1'b1;
    if (!stop) exp_ferr++;
    else if (HAS_PAR && !par_ok) exp_perr++;
    else begin
      exp_q.push_back(d);
      exp_data = d;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    RxD = 1'b1;
    repeat (5) @(negedge clk);
    exp_data = 8'h00;
    n_cmp++; if (RxData !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", RxData); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    n_cmp++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL reset_perr: got %b want 0", parity_err); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
    idle_bits(2);
  endtask

  task automatic test_good_byte();
    int nv = n_valid, nf = n_ferr;
    send(8'hD9, 1'b1, 1'b1);
    idle_bits(1);
    n_cmp++; if (n_valid !== nv + 1) begin n_err++; $display("FAIL good_pulses: got %0d want %0d", n_valid - nv, 1); end
    n_cmp++; if (RxData !== 8'hD9) begin n_err++; $display("FAIL good_data: got %h want d9", RxData); end
    n_cmp++; if (n_ferr !== nf) begin n_err++; $display("FAIL good_ferr: got %0d want 0", n_ferr - nf); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL good_busy: got %b want 0", busy); end
  endtask

  task automatic test_glitch();
    int nv = n_valid, nf = n_ferr, np = n_perr;
    RxD = 1'b0;
    repeat (5) @(negedge clk);
    idle_bits(2);
    n_cmp++; if (n_valid + n_ferr + n_perr !== nv + nf + np) begin n_err++; $display("FAIL glitch_strobes: got %0d want 0", n_valid + n_ferr + n_perr - nv - nf - np); end
    n_cmp++; if (RxData !== exp_data) begin n_err++; $display("FAIL glitch_data: got %h want %h", RxData, exp_data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy: got %b want 0", busy); end
  endtask

  task automatic test_bad_stop();
    int nv = n_valid, nf = n_ferr;
    send(8'h3C, 1'b0, 1'b1);
    idle_bits(2);
    n_cmp++; if (n_ferr !== nf + 1) begin n_err++; $display("FAIL badstop_ferr: got %0d want 1", n_ferr - nf); end
    n_cmp++; if (n_valid !== nv) begin n_err++; $display("FAIL badstop_valid: got %0d want 0", n_valid - nv); end
    n_cmp++; if (RxData !== 8'hD9) begin n_err++; $display("FAIL badstop_data: got %h want d9", RxData); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL badstop_busy: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int qi = got_q.size();
    send(8'h55, 1'b1, 1'b1);
    send(8'hAA, 1'b1, 1'b1);
    idle_bits(1);
    n_cmp++; if (got_q.size() !== qi + 2) begin n_err++; $display("FAIL b2b_count: got %0d want 2", got_q.size() - qi); end
    else begin
      n_cmp++; if (got_q[qi] !== 8'h55) begin n_err++; $display("FAIL b2b_first: got %h want 55", got_q[qi]); end
      n_cmp++; if (got_q[qi+1] !== 8'hAA) begin n_err++; $display("FAIL b2b_second: got %h want aa", got_q[qi+1]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d = 8'hF0;
    int nv = n_valid, nf = n_ferr;
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(d[i]);
    RxD = d[4];
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    exp_data = 8'h00;
    n_cmp++; if (RxData !== 8'h00) begin n_err++; $display("FAIL midreset_data: got %h want 00", RxData); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b want 0", busy); end
    @(negedge clk);
    reset = 1'b0;
    idle_bits(2);
    n_cmp++; if (n_valid + n_ferr !== nv + nf) begin n_err++; $display("FAIL midreset_strobes: got %0d want 0", n_valid + n_ferr - nv - nf); end
    send(8'h0F, 1'b1, 1'b1);
    idle_bits(1);
    n_cmp++; if (RxData !== 8'h0F) begin n_err++; $display("FAIL midreset_next: got %h want 0f", RxData); end
    n_cmp++; if (n_valid !== nv + 1) begin n_err++; $display("FAIL midreset_pulses: got %0d want 1", n_valid - nv); end
  endtask

`ifdef RX_PARITY_EN
  task automatic test_parity();
    int nv = n_valid, np = n_perr;
    send(8'hA5, 1'b1, 1'b0);
    idle_bits(1);
    n_cmp++; if (n_perr !== np + 1) begin n_err++; $display("FAIL parity_err: got %0d want 1", n_perr - np); end
    n_cmp++; if (n_valid !== nv) begin n_err++; $display("FAIL parity_valid: got %0d want 0", n_valid - nv); end
    n_cmp++; if (RxData !== exp_data) begin n_err++; $display("FAIL parity_data: got %h want %h", RxData, exp_data); end
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      logic [7:0] d = 8'($urandom);
      logic stop = $urandom_range(0, 3) != 0;
      logic par_ok = $urandom_range(0, 3) != 0;
      send(d, stop, par_ok);
      n_cmp++; if (RxData !== exp_data) begin n_err++; $display("FAIL rand_data[%0d]: got %h want %h", k, RxData, exp_data); end
      idle_bits(stop ? $urandom_range(0, 2) : 1);
    end
    idle_bits(1);
  endtask

  task automatic test_scoreboard();
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL sb_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    else
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL sb_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
    n_cmp++; if (n_ferr !== exp_ferr) begin n_err++; $display("FAIL sb_ferr: got %0d want %0d", n_ferr, exp_ferr); end
    n_cmp++; if (n_perr !== exp_perr) begin n_err++; $display("FAIL sb_perr: got %0d want %0d", n_perr, exp_perr); end
    n_cmp++; if (n_both !== 0) begin n_err++; $display("FAIL sb_exclusive: got %0d want 0", n_both); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_good_byte();
    test_glitch();
    test_bad_stop();
    test_back_to_back();
    test_reset_mid();
`ifdef RX_PARITY_EN
    test_parity();
`endif
    test_random();
    test_scoreboard();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
